// File: rtl/dbg_pkg.sv
// Shared types and constants for the register-dump debug path.
// REG_DUMP_HEADER_EN adds one address header byte per register.
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SEND
  } reg_dump_state_t;

  localparam int REG_ADDR_W      = 5;
  localparam int UART_FRAME_BITS = 10;

`ifdef REG_DUMP_HEADER_EN
  localparam int DUMP_BYTES_PER_REG = 5;
`else
  localparam int DUMP_BYTES_PER_REG = 4;
`endif

  // Byte i of a word, most significant byte first (i=0 -> w[31:24]).
  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [2:0]  i
  );
    logic [31:0] s;
    s = w << (8 * i);
    return s[31:24];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser with back-to-back byte acceptance.
// ready is high when idle or in the final cycle of a stop bit.
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;
  logic [7:0]        shreg;

  assign ready = !active ||
                 (bit_idx == LAST_BIT && baud_cnt == BAUD_MAX);

  // Bit timing and line drive; a new byte starts on the stop-bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= data;
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_MAX) begin
        baud_cnt <= '0;
        if (bit_idx == LAST_BIT) begin
          active  <= 1'b0;
          bit_idx <= '0;
          tx      <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx < 4'd8) begin
            tx <= shreg[bit_idx[2:0]];
          end else begin
            tx <= 1'b1;
          end
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Walks the regfile debug port and streams each register over UART.
// REG_DUMP_HEADER_EN prefixes each register with {3'b000, reg_addr}.
module reg_dump_tx
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           reg_data,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] LAST_BYTE = 3'(DUMP_BYTES_PER_REG - 1);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR =
    REG_ADDR_W'(NUM_REGS - 1);

  reg_dump_state_t state;
  logic [31:0]     snap;
  logic [2:0]      byte_idx;
  logic            u_valid;
  logic            u_ready;
  logic [7:0]      u_data;
  logic [7:0]      first_byte;
  logic [7:0]      next_byte;

`ifdef REG_DUMP_HEADER_EN
  assign first_byte = {3'b000, reg_addr};
  assign next_byte  = word_byte(snap, byte_idx);
`else
  assign first_byte = word_byte(reg_data, 3'd0);
  assign next_byte  = word_byte(snap, byte_idx + 3'd1);
`endif

  // Byte offered to the serialiser: the first one leaves with the capture.
  always_comb begin
    u_valid = 1'b0;
    u_data  = 8'h00;
    unique case (1'b1)
      state == ADDR: begin
        u_valid = 1'b1;
        u_data  = first_byte;
      end
      state == SEND: begin
        u_valid = byte_idx != LAST_BYTE;
        u_data  = next_byte;
      end
      default: ;
    endcase
  end

  // Dump sequencer: address walk, snapshot capture and byte select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reg_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      snap     <= '0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            state    <= ADDR;
            busy     <= 1'b1;
            reg_addr <= '0;
          end
        end
        ADDR: begin
          state    <= SEND;
          snap     <= reg_data;
          byte_idx <= '0;
        end
        SEND: begin
          if (u_ready) begin
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              if (reg_addr == LAST_ADDR) begin
                state    <= IDLE;
                done     <= 1'b1;
                busy     <= 1'b0;
                reg_addr <= '0;
              end else begin
                state    <= ADDR;
                reg_addr <= reg_addr + 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(u_valid),
    .data (u_data),
    .ready(u_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx (CLKS_PER_BIT=4, NUM_REGS=17).
// Honors REG_DUMP_HEADER_EN when defined for the build.
module tb_reg_dump_tx;

  localparam int CPB = 4;
  localparam int NR  = 17;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR     = 1;
  localparam int EXP_CYC = 3417;
`else
  localparam int HDR     = 0;
  localparam int EXP_CYC = 2737;
`endif
  localparam int BPR = 4 + HDR;
  localparam int NB  = NR * BPR;
  localparam int RC  = 1 + 10 * BPR * CPB;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] regs  [0:31];
  logic [31:0] exp_r [0:16];

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];
  logic [4:0] addr_q [$];
  logic [7:0] rx_b;
  int         frame_err = 0;
  int         done_cnt = 0;
  logic [39:0] t2_obs;
  int          cyc;
  int          bad_tx, bad_busy, bad_done, bad_addr;

  assign reg_data = regs[reg_addr];

  reg_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_REGS    (NR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .reg_data(reg_data),
    .reg_addr(reg_addr),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host-side UART receiver, mid-bit sampling.
  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      repeat (2) @(negedge clk);
      if (tx !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx_b[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx !== 1'b1) frame_err++;
      rx_q.push_back(rx_b);
      @(negedge clk);
    end
  end

  // Address walk and done pulse logger.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 &&
        (addr_q.size() == 0 || reg_addr != addr_q[$]))
      addr_q.push_back(reg_addr);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] w,
                                          input logic [4:0] a,
                                          input int j);
    int k;
    logic [31:0] s;
    if (HDR == 1 && j == 0) return {3'b000, a};
    k = j - HDR;
    s = w >> (24 - 8 * k);
    return s[7:0];
  endfunction

  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int c = 0; c < 40; c++) r[c] = f[c / 4];
    return r;
  endfunction

  task automatic clear_logs();
    rx_q.delete();
    addr_q.delete();
    frame_err = 0;
    done_cnt = 0;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    for (int i = 0; i < 15; i++) regs[i] = 32'hA000_0000 + 32'(i);
    regs[15] = 32'h0000_0005;
    regs[16] = 32'hF000_0000;
    for (int i = 0; i < NR; i++) exp_r[i] = regs[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_dump(input string tag);
    int bad_a;
    int bad_h;
    logic [31:0] w;
    chk({tag, "_nbytes"}, 64'(rx_q.size()), 64'(NB));
    chk({tag, "_framing"}, 64'(frame_err), 64'd0);
    chk({tag, "_naddr"}, 64'(addr_q.size()), 64'(NR));
    if (addr_q.size() == NR) begin
      bad_a = 0;
      for (int i = 0; i < NR; i++)
        if (addr_q[i] !== 5'(i)) bad_a++;
      chk({tag, "_addr_seq"}, 64'(bad_a), 64'd0);
    end
    if (rx_q.size() == NB) begin
      bad_h = 0;
      for (int r = 0; r < NR; r++) begin
        int b;
        b = r * BPR;
        if (HDR == 1 && rx_q[b] !== ref_byte(0, 5'(r), 0)) bad_h++;
        w = {rx_q[b+HDR], rx_q[b+HDR+1], rx_q[b+HDR+2], rx_q[b+HDR+3]};
        chk($sformatf("%s_r%0d", tag, r), 64'(w), 64'(exp_r[r]));
      end
      chk({tag, "_headers"}, 64'(bad_h), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    preload();

    // 1. reset and idle
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(reg_addr), 64'd0);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_addr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (reg_addr !== 5'd0) bad_addr++;
    end
    chk("idle_tx", 64'(bad_tx), 64'd0);
    chk("idle_busy", 64'(bad_busy), 64'd0);
    chk("idle_done", 64'(bad_done), 64'd0);
    chk("idle_addr", 64'(bad_addr), 64'd0);

    // 2. exact bit timing of R0 = 0x12345678
    regs[0] = 32'h1234_5678;
    exp_r[0] = regs[0];
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_tx_addr_cycle", 64'(tx), 64'd1);
    for (int j = 0; j < BPR; j++) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        t2_obs[c] = tx;
      end
      chk($sformatf("t2_frame%0d", j), 64'(t2_obs),
          64'(frame_bits(ref_byte(32'h1234_5678, 5'd0, j))));
    end
    wait_done(4000, cyc);
    chk("t2_done_seen", 64'(done), 64'd1);
    repeat (5) @(negedge clk);
    check_dump("t2");

    // 3. full dump with latency
    preload();
    clear_logs();
    pulse_start();
    wait_done(5000, cyc);
    chk("t3_done_seen", 64'(done), 64'd1);
    chk("t3_latency", 64'(cyc), 64'(EXP_CYC));
    chk("t3_busy_at_done", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    chk("t3_done_once", 64'(done_cnt), 64'd1);
    check_dump("t3");

    // 4+5. snapshot hold and start while busy
    regs[3] = 32'h1111_1111;
    exp_r[3] = regs[3];
    clear_logs();
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      if (cyc == 3 * RC + 40) begin
        chk("t4_addr_at_write", 64'(reg_addr), 64'd3);
        regs[3] = 32'hDEAD_BEEF;
      end
      start = (cyc == 1000);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t5_latency", 64'(cyc), 64'(EXP_CYC));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_no_restart", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    chk("t5_busy_low", 64'(busy), 64'd0);
    chk("t5_done_once", 64'(done_cnt), 64'd1);
    check_dump("t4");

    // 6. reset during a data bit of R7
    exp_r[3] = 32'hDEAD_BEEF;
    clear_logs();
    pulse_start();
    cyc = 0;
    while (reg_addr !== 5'd7 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t6_reached_r7", 64'(reg_addr), 64'd7);
    repeat (18) @(posedge clk);
    #1;
    chk("t6_tx_data_bit", 64'(tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", 64'(tx), 64'd1);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_addr", 64'(reg_addr), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    clear_logs();
    pulse_start();
    wait_done(5000, cyc);
    chk("t6_latency", 64'(cyc), 64'(EXP_CYC));
    repeat (20) @(negedge clk);
    chk("t6_done_once", 64'(done_cnt), 64'd1);
    check_dump("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
